// File: rtl/eth_rx_decap.sv
// eth_rx_decap: GMII receive decapsulation -- strips preamble/SFD, captures
// the Ethernet header, forwards the payload with the FCS removed, and reports
// CRC-32 / length / PHY error status once per frame.
//
// Optional feature macro: ETH_RX_ADDR_FILTER_EN
//   defined     -> accept only frames addressed to LOCAL_MAC or broadcast
//   not defined -> promiscuous, every frame is accepted
//
// Ports:
//   eth_rx_clk  receive clock, all logic on its rising edge
//   arst_n      asynchronous active-low reset
//   rxd/rx_dv/rx_er          GMII receive byte, data valid, receive error
//   dst_mac/src_mac/ethertype captured header fields (first byte in MSBs)
//   hdr_valid   one-cycle pulse when the header is complete
//   data_out/data_valid      payload byte stream, FCS stripped
//   frame_done  one-cycle end-of-frame strobe carrying the status below
//   frame_ok, err_crc, err_len, err_phy, pay_len  frame status
module eth_rx_decap #(
   parameter logic [47:0] LOCAL_MAC = 48'h702227acdb65,
   parameter int          MIN_FRAME = 64,
   parameter int          MAX_FRAME = 1522
) (
   input  logic        eth_rx_clk,
   input  logic        arst_n,
   input  logic [7:0]  rxd,
   input  logic        rx_dv,
   input  logic        rx_er,
   output logic [47:0] dst_mac,
   output logic [47:0] src_mac,
   output logic [15:0] ethertype,
   output logic        hdr_valid,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        err_crc,
   output logic        err_len,
   output logic        err_phy,
   output logic [10:0] pay_len
);
   typedef enum logic [2:0] {IDLE, PRE, DST, SRC, TYP, PAY, DISC} state_t;

   localparam logic [10:0] MIN_L   = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_L   = 11'(MAX_FRAME);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
`ifdef ETH_RX_ADDR_FILTER_EN
   localparam logic FILTER = 1'b1;
`else
   localparam logic FILTER = 1'b0;
`endif

   state_t      state, state_nx;
   logic [10:0] cnt;
   logic [10:0] beats;
   logic [31:0] crc;
   logic [31:0] dline;
   logic [2:0]  fill;
   logic        phy;
   logic [47:0] dst_nx;
   logic [10:0] cnt_nx;
   logic        dst_hit, in_frame, sfd, trunc, bad_len, bad_crc;

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

   // dst_nx is the full address once the 6th byte is on rxd
   assign dst_nx   = {dst_mac[39:0], rxd};
   assign dst_hit  = !FILTER || dst_nx == LOCAL_MAC || &dst_nx;
   assign cnt_nx   = &cnt ? cnt : cnt + 11'd1;
   assign in_frame = state == DST || state == SRC || state == TYP || state == PAY;
   assign sfd      = state == PRE && rx_dv && rxd == 8'hD5;
   // rx_dv falling before the payload starts means the header was cut short
   assign trunc    = state != PAY;
   assign bad_len  = trunc || cnt < MIN_L || cnt > MAX_L;
   assign bad_crc  = trunc || crc != RESIDUE;

   always_ff @(posedge eth_rx_clk or negedge arst_n)
      if (!arst_n) state <= IDLE;
      else         state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rx_dv) state_nx = rxd == 8'h55 ? PRE : DISC;
         PRE:     state_nx = !rx_dv ? IDLE : rxd == 8'hD5 ? DST : rxd == 8'h55 ? PRE : DISC;
         DST:     state_nx = !rx_dv ? IDLE : cnt == 11'd5 ? (dst_hit ? SRC : DISC) : DST;
         SRC:     state_nx = !rx_dv ? IDLE : cnt == 11'd11 ? TYP : SRC;
         TYP:     state_nx = !rx_dv ? IDLE : cnt == 11'd13 ? PAY : TYP;
         PAY:     state_nx = !rx_dv ? IDLE : PAY;
         DISC:    state_nx = !rx_dv ? IDLE : DISC;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge eth_rx_clk or negedge arst_n)
      if (!arst_n) begin
         dst_mac    <= '0;
         src_mac    <= '0;
         ethertype  <= '0;
         hdr_valid  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         err_crc    <= 1'b0;
         err_len    <= 1'b0;
         err_phy    <= 1'b0;
         pay_len    <= '0;
         cnt        <= '0;
         beats      <= '0;
         crc        <= '1;
         dline      <= '0;
         fill       <= '0;
         phy        <= 1'b0;
      end else begin
         hdr_valid  <= 1'b0;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         if (sfd) begin
            cnt   <= '0;
            beats <= '0;
            crc   <= '1;
            fill  <= '0;
            phy   <= 1'b0;
         end
         if (in_frame && rx_dv) begin
            cnt <= cnt_nx;
            crc <= crc_next(crc, rxd);
            if (rx_er) phy <= 1'b1;
            if (state == DST) dst_mac <= dst_nx;
            if (state == SRC) src_mac <= {src_mac[39:0], rxd};
            if (state == TYP) ethertype <= {ethertype[7:0], rxd};
            if (state == TYP && cnt == 11'd13) hdr_valid <= 1'b1;
            if (state == PAY) begin
               // 4-byte delay line: a byte leaves only when a newer one arrives,
               // so the last four bytes (the FCS) are never emitted
               dline <= {dline[23:0], rxd};
               if (fill != 3'd4) fill <= fill + 3'd1;
               else if (cnt_nx <= MAX_L) begin
                  data_out   <= dline[31:24];
                  data_valid <= 1'b1;
                  beats      <= beats + 11'd1;
               end
            end
         end
         if (in_frame && !rx_dv) begin
            frame_done <= 1'b1;
            err_len    <= bad_len;
            err_crc    <= bad_crc;
            err_phy    <= phy;
            frame_ok   <= !(bad_len || bad_crc || phy);
            pay_len    <= beats;
         end
      end
endmodule

// File: doc/eth_rx_decap.md
# eth_rx_decap

Receive-side decapsulation for the Ethernet MAC, the counterpart of the transmit encapsulation path. It consumes a GMII byte stream in the `eth_rx_clk` domain and strips the preamble and SFD. It captures the destination MAC, source MAC and EtherType, forwards payload bytes with the 4-byte FCS removed, and checks CRC-32 and frame length. A single frame-status pulse follows each frame; the downstream RX async FIFO commits or discards the frame on that pulse.

## Interface
- `LOCAL_MAC`, default 48'h702227acdb65: station address accepted by the filter.
- `MIN_FRAME`, default 64: minimum legal frame size, dst through FCS.
- `MAX_FRAME`, default 1522: maximum legal frame size, dst through FCS.
- `eth_rx_clk`  in  1  receive clock; all logic is on its rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `rxd`  in  8  GMII receive data.
- `rx_dv`  in  1  GMII data valid.
- `rx_er`  in  1  GMII receive error.
- `dst_mac`  out  48  captured destination address (first byte received = [47:40]).
- `src_mac`  out  48  captured source address (same byte order).
- `ethertype`  out  16  captured type/length; first byte = [15:8].
- `hdr_valid`  out  1  one-cycle pulse; all header fields are stable from this pulse until the next frame's SFD.
- `data_out`  out  8  payload byte.
- `data_valid`  out  1  `data_out` is valid this cycle.
- `frame_done`  out  1  one-cycle end-of-frame status strobe.
- `frame_ok`  out  1  valid with `frame_done`; high iff all error flags are low.
- `err_crc`, `err_len`, `err_phy`  out  1 each  valid with `frame_done`.
- `pay_len`  out  11  number of payload bytes emitted; valid with `frame_done`.

## Operation
- Reset value of every output is 0. State resets to IDLE.
- States and transitions:
  - IDLE: `rx_dv` high with `rxd`=0x55 → PRE. `rx_dv` high with any other byte → DISCARD.
  - PRE: 0x55 → stay in PRE. 0xD5 → DST. Other byte, or `rx_dv` low → DISCARD/IDLE. PRE and DISCARD never produce `frame_done`.
  - DST: 6 bytes. After the 6th byte, a filter miss → DISCARD (see Configuration). Otherwise → SRC.
  - SRC: 6 bytes, then TYPE.
  - TYPE: 2 bytes. `hdr_valid` pulses the cycle after the 2nd byte is sampled. → PAYLOAD.
  - PAYLOAD: until `rx_dv` falls, then `frame_done` → IDLE.
  - DISCARD: wait for `rx_dv` low → IDLE.
- FCS stripping: every byte after EtherType enters a 4-byte delay line. A byte is emitted only when a newer byte displaces it. The 4 bytes remaining at `rx_dv` fall are the FCS and are never output.
- CRC: reflected CRC-32, polynomial 0xEDB88320, register preset to 0xFFFFFFFF at SFD.
  - Every byte from the first DST byte through the last FCS byte is folded in.
  - Good frame iff the final register equals 0xDEBB20E3. Otherwise `err_crc`=1.
- Length: an 11-bit byte counter covers DST through FCS and saturates at 2047.
  - `err_len`=1 if count < `MIN_FRAME` or count > `MAX_FRAME`.
  - `err_len`=1 if `rx_dv` falls in DST, SRC or TYPE. Such a frame still produces `frame_done`, with `err_crc` forced to 1.
  - Once count exceeds `MAX_FRAME`, payload output stops; status is still reported at `rx_dv` fall.
- `err_phy`: sticky per frame. Set if `rx_er` is high in any cycle with `rx_dv` high in DST…PAYLOAD.
- `pay_len` = count − 18 when count ≥ 18. Equals the number of `data_valid` beats.

## Timing
- Header fields update the cycle after their last byte is sampled.
- Payload latency: byte k appears on `data_out` the cycle after byte k+4 is sampled. There is at most one beat per cycle and no backpressure.
- `frame_done` asserts for exactly one cycle, the cycle after the first sample with `rx_dv` low in DST…PAYLOAD. Status outputs hold until the next `frame_done`. `data_valid` is never high in the same cycle as `frame_done`.
- Back-to-back frames: `rx_dv` low for a single cycle is sufficient; IDLE accepts a new preamble in the cycle of `frame_done`.
- Reset mid-frame: outputs clear immediately. If `rx_dv` is still high after release, IDLE sees a non-0x55 byte and goes to DISCARD; no partial status is emitted.

## Configuration
- `ETH_RX_ADDR_FILTER_EN` defined:
  - After DST, the frame is accepted only if `dst_mac` == `LOCAL_MAC` or 48'hFFFFFFFFFFFF.
  - A miss → DISCARD, with no `hdr_valid`, no payload and no `frame_done`.
- Not defined: every frame is accepted (promiscuous mode).

## Test plan
- 7×0x55, 0xD5, dst=`LOCAL_MAC`, src=48'h023528fbdd66, type 0x0800, 46-byte payload 0x00..0x2D, correct FCS → `hdr_valid` once; 46 beats 0x00..0x2D; `frame_done`, `frame_ok`=1, `pay_len`=46.
- Same frame with the last FCS byte XOR 0x01 → identical payload beats; `err_crc`=1, `frame_ok`=0.
- 40-byte payload with valid FCS (count 58) → `err_len`=1, `pay_len`=40. A 1510-byte payload → `err_len`=1, and output stops after count 1522.
- `rx_er` pulsed for 1 cycle mid-payload → `err_phy`=1, `frame_ok`=0. `rx_dv` dropped after 3 SRC bytes → `frame_done` with `err_len`=1 and `err_crc`=1.
- With the filter macro, dst=48'h112233445566 → no `hdr_valid`, no `data_valid`, no `frame_done`. Broadcast dst → accepted. Without the macro, dst=48'h112233445566 → accepted.
- `arst_n` low for 2 cycles mid-payload → all outputs 0; no `frame_done` for the truncated frame. The next frame, after 1 idle cycle, decodes correctly.
